hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The parameter list SHALL be: CNT_WIDTH, 32, width of the performance counters.
REQ-002 The port list SHALL be, one port per line:
- clk  in  1  single clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- IFID_rs1, IFID_rs2  in  5 each  source registers of the instruction in ID.
- IFID_use_rs1, IFID_use_rs2  in  1 each  the ID instruction reads that source.
- IDEX_rd  in  5  destination register of the instruction in EX.
- IDEX_mem_read  in  1  the EX instruction is a load.
- EX_redirect  in  1  taken branch or jump resolved in EX this cycle.
- imem_read  in  1  a fetch request is active.
- imem_resp  in  1  fetch data valid, one-cycle pulse.
- dmem_req  in  1  a MEM-stage read or write is active.
- dmem_resp  in  1  MEM access done, one-cycle pulse.
- load_pc, load_IFID, load_IDEX, load_EXMEM, load_MEMWB  out  1 each  pipeline register enables.
- flush_IFID, flush_IDEX  out  1 each  load a bubble instead of the incoming data.
- latch_target  out  1  capture the EX redirect target into the datapath target register.
- pc_from_latch  out  1  the PC mux selects the latched target.
- squash_fetch  out  1  discard the fetch data arriving this cycle.
- ifbuf_sel  out  1  IFID loads from the fetch buffer, not from imem.
- ctrl_state  out  1  0 = RUN, 1 = REDIR_WAIT.
- stall_count  out  CNT_WIDTH  stall cycles counted.
- flush_count  out  CNT_WIDTH  redirects accepted.

Function
REQ-003 The signal definitions SHALL be:
- dstall = dmem_req & ~dmem_resp.
- fetch_ok = imem_resp | fetch_ready.
- istall = imem_read & ~fetch_ok.
- lu_hazard = IDEX_mem_read & (IDEX_rd != 0) & ((IFID_use_rs1 & IFID_rs1 == IDEX_rd) | (IFID_use_rs2 & IFID_rs2 == IDEX_rd)).
REQ-004 All outputs except the counters SHALL be combinational from the current state, fetch_ready and the inputs; every output not driven by a rule below SHALL be 0.
REQ-005 In RUN, the first matching rule in REQ-006 to REQ-011 SHALL apply.
REQ-006 dstall: all load_* = 0 and all flushes = 0; EX_redirect is ignored, because EX is held and presents it again.
REQ-007 EX_redirect & istall:
- latch_target = 1.
- load_IFID/IDEX/EXMEM/MEMWB = 1, flush_IFID = 1, flush_IDEX = 1, load_pc = 0.
- next state REDIR_WAIT.
REQ-008 EX_redirect & ~istall:
- load_pc = 1 (pc_from_latch = 0), all other load_* = 1.
- flush_IFID = 1, flush_IDEX = 1.
- clear fetch_ready.
REQ-009 lu_hazard: load_pc = 0, load_IFID = 0, load_IDEX/EXMEM/MEMWB = 1, flush_IDEX = 1; exactly one bubble per hazard.
REQ-010 istall: load_pc = 0, load_IFID = 1 with flush_IFID = 1, back stages load = 1.
REQ-011 Otherwise: all load_* = 1.
REQ-012 In REDIR_WAIT:
- dstall: freeze as in REQ-006.
- else if ~fetch_ok: load_IFID = 1 with flush_IFID = 1, back stages load = 1, load_pc = 0.
- else: squash_fetch = 1, load_pc = 1, pc_from_latch = 1, flush_IFID = 1, all load_* = 1, clear fetch_ready, next state RUN.
- EX_redirect is ignored.
REQ-013 fetch_ready (register) SHALL set on imem_resp in any cycle where load_pc = 0 and the state is not leaving REDIR_WAIT.
REQ-014 fetch_ready SHALL clear when load_pc = 1 and SHALL otherwise hold.
REQ-015 ifbuf_sel SHALL equal fetch_ready whenever load_IFID = 1 and flush_IFID = 0.
REQ-016 stall_count SHALL increment in each cycle where load_MEMWB = 0 or flush_IDEX = 1, and SHALL saturate at all-ones.
REQ-017 flush_count SHALL increment once per accepted redirect (REQ-007 or REQ-008), and SHALL saturate at all-ones.
REQ-018 A redirect taken via REDIR_WAIT SHALL count once, on entry to REDIR_WAIT.

Reset
REQ-019 On rst = 1 at a clk edge: state = RUN, fetch_ready = 0, stall_count = 0, flush_count = 0.
REQ-020 A reset taken mid-operation (including in REDIR_WAIT) SHALL abandon the pending redirect without asserting squash_fetch.
REQ-021 In the cycle after reset, the outputs SHALL follow the RUN rules.

Verification
REQ-022 Load-use: IDEX_mem_read = 1, IDEX_rd = 5, IFID_rs2 = 5, IFID_use_rs2 = 1 -> one cycle of load_pc = 0, load_IFID = 0, flush_IDEX = 1; stall_count +1.
REQ-023 x0 load: same as REQ-022 with IDEX_rd = 0 -> no stall; all load_* = 1.
REQ-024 Redirect during fetch miss: EX_redirect = 1, imem_read = 1, imem_resp = 0 -> latch_target = 1 and REDIR_WAIT; imem_resp 3 cycles later -> squash_fetch = 1, load_pc = 1, pc_from_latch = 1, back to RUN; flush_count = 1.
REQ-025 dmem stall with fetch return: dmem_req = 1 for 4 cycles, imem_resp during cycle 2 -> all load_* = 0 for 4 cycles; fetch_ready = 1; next cycle ifbuf_sel = 1 and load_pc = 1.
REQ-026 Simultaneous redirect and load-use: EX_redirect = 1 with lu_hazard = 1 -> the redirect rule wins (load_pc = 1, both flushes), with no extra bubble.
REQ-027 Reset in REDIR_WAIT: rst = 1 -> ctrl_state = 0, counters = 0, no squash_fetch pulse.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, I/D memory stalls, EX redirects with a pending-fetch wait state.
// Outputs are combinational from state/fetch_ready/inputs; counters update one cycle later and saturate.
module hazard_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           IFID_rs1,
  input  logic [4:0]           IFID_rs2,
  input  logic                 IFID_use_rs1,
  input  logic                 IFID_use_rs2,
  input  logic [4:0]           IDEX_rd,
  input  logic                 IDEX_mem_read,
  input  logic                 EX_redirect,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  output logic                 load_pc,
  output logic                 load_IFID,
  output logic                 load_IDEX,
  output logic                 load_EXMEM,
  output logic                 load_MEMWB,
  output logic                 flush_IFID,
  output logic                 flush_IDEX,
  output logic                 latch_target,
  output logic                 pc_from_latch,
  output logic                 squash_fetch,
  output logic                 ifbuf_sel,
  output logic                 ctrl_state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   fetch_ready_q, fetch_ready_d;
  logic [CNT_WIDTH-1:0]   stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0]   flush_count_q, flush_count_d;

  logic dstall, fetch_ok, istall, lu_hazard;
  logic redirect_acc;
  logic leaving_wait;

  assign dstall    = dmem_req & ~dmem_resp;
  assign fetch_ok  = imem_resp | fetch_ready_q;
  assign istall    = imem_read & ~fetch_ok;
  assign lu_hazard = IDEX_mem_read & (IDEX_rd != 5'd0) &
                     ((IFID_use_rs1 & (IFID_rs1 == IDEX_rd)) |
                      (IFID_use_rs2 & (IFID_rs2 == IDEX_rd)));

  always_comb begin
    load_pc       = 1'b0;
    load_IFID     = 1'b0;
    load_IDEX     = 1'b0;
    load_EXMEM    = 1'b0;
    load_MEMWB    = 1'b0;
    flush_IFID    = 1'b0;
    flush_IDEX    = 1'b0;
    latch_target  = 1'b0;
    pc_from_latch = 1'b0;
    squash_fetch  = 1'b0;
    redirect_acc  = 1'b0;
    leaving_wait  = 1'b0;
    state_d       = state_q;

    case (state_q)
      RUN: begin
        if (dstall) begin
          // Whole pipe frozen; EX keeps presenting any redirect until it is released.
        end else if (EX_redirect && istall) begin
          latch_target = 1'b1;
          load_IFID    = 1'b1;
          load_IDEX    = 1'b1;
          load_EXMEM   = 1'b1;
          load_MEMWB   = 1'b1;
          flush_IFID   = 1'b1;
          flush_IDEX   = 1'b1;
          redirect_acc = 1'b1;
          state_d      = REDIR_WAIT;
        end else if (EX_redirect) begin
          load_pc      = 1'b1;
          load_IFID    = 1'b1;
          load_IDEX    = 1'b1;
          load_EXMEM   = 1'b1;
          load_MEMWB   = 1'b1;
          flush_IFID   = 1'b1;
          flush_IDEX   = 1'b1;
          redirect_acc = 1'b1;
        end else if (lu_hazard) begin
          load_IDEX  = 1'b1;
          load_EXMEM = 1'b1;
          load_MEMWB = 1'b1;
          flush_IDEX = 1'b1;
        end else if (istall) begin
          load_IFID  = 1'b1;
          flush_IFID = 1'b1;
          load_IDEX  = 1'b1;
          load_EXMEM = 1'b1;
          load_MEMWB = 1'b1;
        end else begin
          load_pc    = 1'b1;
          load_IFID  = 1'b1;
          load_IDEX  = 1'b1;
          load_EXMEM = 1'b1;
          load_MEMWB = 1'b1;
        end
      end

      REDIR_WAIT: begin
        if (dstall) begin
          // Frozen; the wrong-path fetch may still land in the buffer.
        end else if (!fetch_ok) begin
          load_IFID  = 1'b1;
          flush_IFID = 1'b1;
          load_IDEX  = 1'b1;
          load_EXMEM = 1'b1;
          load_MEMWB = 1'b1;
        end else begin
          // Wrong-path fetch completes: drop it and restart from the latched target.
          squash_fetch  = ~rst;
          load_pc       = 1'b1;
          pc_from_latch = 1'b1;
          flush_IFID    = 1'b1;
          load_IFID     = 1'b1;
          load_IDEX     = 1'b1;
          load_EXMEM    = 1'b1;
          load_MEMWB    = 1'b1;
          leaving_wait  = 1'b1;
          state_d       = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    ifbuf_sel = load_IFID & ~flush_IFID & fetch_ready_q;
  end

  always_comb begin
    fetch_ready_d = fetch_ready_q;
    if (load_pc)
      fetch_ready_d = 1'b0;
    else if (imem_resp && !leaving_wait)
      fetch_ready_d = 1'b1;

    stall_count_d = stall_count_q;
    if ((!load_MEMWB || flush_IDEX) && !(&stall_count_q))
      stall_count_d = stall_count_q + CNT_ONE;

    flush_count_d = flush_count_q;
    if (redirect_acc && !(&flush_count_q))
      flush_count_d = flush_count_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_ready_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_ready_q <= fetch_ready_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign ctrl_state  = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus random traffic against a rule-table model.
module tb_hazard_controller;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic IFID_use_rs1, IFID_use_rs2, IDEX_mem_read, EX_redirect;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic load_pc, load_IFID, load_IDEX, load_EXMEM, load_MEMWB;
  logic flush_IFID, flush_IDEX, latch_target, pc_from_latch, squash_fetch, ifbuf_sel, ctrl_state;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_mem_read(IDEX_mem_read),
    .EX_redirect(EX_redirect),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_IFID(load_IFID), .load_IDEX(load_IDEX),
    .load_EXMEM(load_EXMEM), .load_MEMWB(load_MEMWB),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .latch_target(latch_target), .pc_from_latch(pc_from_latch),
    .squash_fetch(squash_fetch), .ifbuf_sel(ifbuf_sel), .ctrl_state(ctrl_state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  wire [11:0] obs = {load_pc, load_IFID, load_IDEX, load_EXMEM, load_MEMWB,
                     flush_IFID, flush_IDEX, latch_target, pc_from_latch,
                     squash_fetch, ifbuf_sel, ctrl_state};
  wire [4:0] loads = obs[11:7];

  // Reference model state: mode 0 = RUN, 1 = waiting for wrong-path fetch.
  logic m_mode, m_fr;
  logic [CW-1:0] m_sc, m_fc;
  logic [CW-1:0] cmax = {CW{1'b1}};
  logic [11:0] e_vec;
  logic p_next, p_fr, p_acc, p_stall;

  task automatic predict();
    logic ds, fok, is, lu, fif, fid, lt, pfl, sq, ifb;
    logic [4:0] ld;
    ds  = dmem_req && !dmem_resp;
    fok = imem_resp || m_fr;
    is  = imem_read && !fok;
    lu  = IDEX_mem_read && (IDEX_rd != 0) &&
          ((IFID_use_rs1 && IFID_rs1 == IDEX_rd) || (IFID_use_rs2 && IFID_rs2 == IDEX_rd));
    ld = 5'b00000; fif = 0; fid = 0; lt = 0; pfl = 0; sq = 0;
    p_acc = 0; p_next = m_mode;
    if (!m_mode) begin
      if (ds) ld = 5'b00000;
      else if (EX_redirect && is) begin lt = 1; ld = 5'b01111; fif = 1; fid = 1; p_acc = 1; p_next = 1; end
      else if (EX_redirect) begin ld = 5'b11111; fif = 1; fid = 1; p_acc = 1; end
      else if (lu) begin ld = 5'b00111; fid = 1; end
      else if (is) begin ld = 5'b01111; fif = 1; end
      else ld = 5'b11111;
    end else begin
      if (ds) ld = 5'b00000;
      else if (!fok) begin ld = 5'b01111; fif = 1; end
      else begin sq = !rst; ld = 5'b11111; pfl = 1; fif = 1; p_next = 0; end
    end
    ifb = ld[3] && !fif && m_fr;
    e_vec = {ld, fif, fid, lt, pfl, sq, ifb, m_mode};
    if (ld[4]) p_fr = 0;
    else if (imem_resp) p_fr = 1;
    else p_fr = m_fr;
    p_stall = !ld[0] || fid;
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_fr = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_mode = p_next;
      m_fr = p_fr;
      if (p_stall && m_sc != cmax) m_sc = m_sc + 1'b1;
      if (p_acc && m_fc != cmax) m_fc = m_fc + 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    IFID_rs1 = 0; IFID_rs2 = 0; IFID_use_rs1 = 0; IFID_use_rs2 = 0;
    IDEX_rd = 0; IDEX_mem_read = 0; EX_redirect = 0;
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ctrl_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b want=0", ctrl_state); end
    checks++;
    if (stall_count !== 0 || flush_count !== 0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    checks++;
    if (obs !== 12'b11111_0000000) begin failures++; $display("FAIL reset_outputs got=%b want=%b", obs, 12'b11111_0000000); end
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_mem_read = 1; IDEX_rd = 5; IFID_rs2 = 5; IFID_use_rs2 = 1;
    #1;
    checks++;
    if (loads !== 5'b00111 || flush_IDEX !== 1'b1 || flush_IFID !== 1'b0) begin
      failures++; $display("FAIL load_use_bubble got loads=%b fid=%b fif=%b want loads=00111 fid=1 fif=0", loads, flush_IDEX, flush_IFID);
    end
    tick();
    IDEX_mem_read = 0; IDEX_rd = 0;
    #1;
    checks++;
    if (stall_count !== 1) begin failures++; $display("FAIL load_use_count got=%0d want=1", stall_count); end
    checks++;
    if (loads !== 5'b11111 || flush_IDEX !== 1'b0) begin
      failures++; $display("FAIL load_use_single got loads=%b fid=%b want 11111/0", loads, flush_IDEX);
    end
    tick();
  endtask

  task automatic test_x0_load();
    do_reset();
    IDEX_mem_read = 1; IDEX_rd = 0; IFID_rs2 = 0; IFID_use_rs2 = 1;
    #1;
    checks++;
    if (loads !== 5'b11111 || flush_IDEX !== 1'b0) begin
      failures++; $display("FAIL x0_load got loads=%b fid=%b want 11111/0", loads, flush_IDEX);
    end
    tick();
    checks++;
    if (stall_count !== 0) begin failures++; $display("FAIL x0_count got=%0d want=0", stall_count); end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    EX_redirect = 1; imem_read = 1; imem_resp = 0;
    #1;
    checks++;
    if (latch_target !== 1'b1 || load_pc !== 1'b0 || loads !== 5'b01111 || flush_IFID !== 1'b1 || flush_IDEX !== 1'b1) begin
      failures++; $display("FAIL redir_miss_entry got lt=%b loads=%b fif=%b fid=%b want 1/01111/1/1", latch_target, loads, flush_IFID, flush_IDEX);
    end
    tick();
    EX_redirect = 0;
    checks++;
    if (ctrl_state !== 1'b1 || flush_count !== 1) begin
      failures++; $display("FAIL redir_miss_wait got st=%b fc=%0d want 1/1", ctrl_state, flush_count);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (squash_fetch !== 1'b0 || loads !== 5'b01111 || flush_IFID !== 1'b1) begin
        failures++; $display("FAIL redir_miss_hold%0d got sq=%b loads=%b fif=%b want 0/01111/1", i, squash_fetch, loads, flush_IFID);
      end
      tick();
    end
    imem_resp = 1;
    #1;
    checks++;
    if (squash_fetch !== 1'b1 || load_pc !== 1'b1 || pc_from_latch !== 1'b1 || flush_IFID !== 1'b1) begin
      failures++; $display("FAIL redir_miss_exit got sq=%b lpc=%b pfl=%b fif=%b want 1/1/1/1", squash_fetch, load_pc, pc_from_latch, flush_IFID);
    end
    tick();
    imem_resp = 0; imem_read = 0;
    checks++;
    if (ctrl_state !== 1'b0 || flush_count !== 1) begin
      failures++; $display("FAIL redir_miss_done got st=%b fc=%0d want 0/1", ctrl_state, flush_count);
    end
  endtask

  task automatic test_dmem_fetch();
    do_reset();
    imem_read = 1; dmem_req = 1;
    for (int i = 0; i < 4; i++) begin
      imem_resp = (i == 1);
      #1;
      checks++;
      if (loads !== 5'b00000) begin failures++; $display("FAIL dmem_freeze%0d got=%b want=00000", i, loads); end
      tick();
    end
    dmem_req = 0; imem_resp = 0;
    #1;
    checks++;
    if (ifbuf_sel !== 1'b1 || load_pc !== 1'b1) begin
      failures++; $display("FAIL dmem_ifbuf got ifb=%b lpc=%b want 1/1", ifbuf_sel, load_pc);
    end
    checks++;
    if (stall_count !== 4) begin failures++; $display("FAIL dmem_count got=%0d want=4", stall_count); end
    tick();
  endtask

  task automatic test_redirect_lu();
    do_reset();
    EX_redirect = 1; IDEX_mem_read = 1; IDEX_rd = 7; IFID_rs1 = 7; IFID_use_rs1 = 1;
    #1;
    checks++;
    if (loads !== 5'b11111 || flush_IFID !== 1'b1 || flush_IDEX !== 1'b1 || latch_target !== 1'b0) begin
      failures++; $display("FAIL redir_lu got loads=%b fif=%b fid=%b lt=%b want 11111/1/1/0", loads, flush_IFID, flush_IDEX, latch_target);
    end
    tick();
    EX_redirect = 0; IDEX_mem_read = 0;
    #1;
    checks++;
    if (loads !== 5'b11111 || flush_IDEX !== 1'b0 || flush_count !== 1 || stall_count !== 1) begin
      failures++; $display("FAIL redir_lu_after got loads=%b fid=%b fc=%0d sc=%0d want 11111/0/1/1", loads, flush_IDEX, flush_count, stall_count);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    EX_redirect = 1; imem_read = 1;
    tick();
    EX_redirect = 0;
    tick();
    rst = 1;
    #1;
    checks++;
    if (squash_fetch !== 1'b0 || ctrl_state !== 1'b1) begin
      failures++; $display("FAIL rst_wait_pre got sq=%b st=%b want 0/1", squash_fetch, ctrl_state);
    end
    tick();
    rst = 0; imem_resp = 1;
    #1;
    checks++;
    if (ctrl_state !== 1'b0 || stall_count !== 0 || flush_count !== 0) begin
      failures++; $display("FAIL rst_wait_post got st=%b sc=%0d fc=%0d want 0/0/0", ctrl_state, stall_count, flush_count);
    end
    checks++;
    if (squash_fetch !== 1'b0 || load_pc !== 1'b1 || pc_from_latch !== 1'b0) begin
      failures++; $display("FAIL rst_wait_run got sq=%b lpc=%b pfl=%b want 0/1/0", squash_fetch, load_pc, pc_from_latch);
    end
    tick();
    imem_resp = 0; imem_read = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < 20; i++) tick();
    dmem_req = 0;
    checks++;
    if (stall_count !== cmax) begin failures++; $display("FAIL stall_sat got=%0d want=%0d", stall_count, cmax); end
    EX_redirect = 1;
    for (int i = 0; i < 20; i++) tick();
    EX_redirect = 0;
    checks++;
    if (flush_count !== cmax) begin failures++; $display("FAIL flush_sat got=%0d want=%0d", flush_count, cmax); end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      IFID_rs1      = 5'($urandom_range(0, 3));
      IFID_rs2      = 5'($urandom_range(0, 3));
      IDEX_rd       = 5'($urandom_range(0, 3));
      IFID_use_rs1  = 1'($urandom_range(0, 1));
      IFID_use_rs2  = 1'($urandom_range(0, 1));
      IDEX_mem_read = 1'($urandom_range(0, 1));
      EX_redirect   = ($urandom_range(0, 5) == 0);
      imem_read     = ($urandom_range(0, 3) != 0);
      imem_resp     = ($urandom_range(0, 2) == 0);
      dmem_req      = ($urandom_range(0, 3) == 0);
      dmem_resp     = ($urandom_range(0, 2) == 0);
      #1;
      predict();
      checks++;
      if (obs !== e_vec) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL random_outputs cycle=%0d got=%b want=%b", i, obs, e_vec);
      end
      tick();
      checks++;
      if (stall_count !== m_sc || flush_count !== m_fc) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL random_counters cycle=%0d got=%0d/%0d want=%0d/%0d", i, stall_count, flush_count, m_sc, m_fc);
      end
    end
    idle_inputs();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_mode = 0; m_fr = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect_miss();
    test_dmem_fetch();
    test_redirect_lu();
    test_reset_in_wait();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
